// File: rtl/ex_muldiv_ctrl.sv
// Iterative multiply/divide sequencer with architectural HI/LO registers beside the EX-stage ALU.
// Optional MULDIV_FAST_MUL_EN swaps the 32-step shift-add multiplier for a single-cycle product.
module ex_muldiv_ctrl #(
    parameter int unsigned       DATA_W  = 32,
    parameter logic [DATA_W-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_start,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_dataA,
    input  logic [DATA_W-1:0] in_dataB,
    input  logic              in_flush,
    output logic              out_busy,
    output logic              out_done,
    output logic              out_div_by_zero,
    output logic [DATA_W-1:0] out_hi,
    output logic [DATA_W-1:0] out_lo
);

    localparam int unsigned      CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e                state_q, state_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  is_div_q, is_div_d;
    logic                  neg_lo_q, neg_lo_d;
    logic                  neg_hi_q, neg_hi_d;
    logic                  dz_q, dz_d;
    logic                  done_q, done_d;
    logic                  dz_pulse_q, dz_pulse_d;

    logic                  signed_op, sign_a, sign_b;
    logic [DATA_W:0]       rem_sh;
    logic                  div_ge;
    logic [DATA_W-1:0]     div_sub;
    logic [2*DATA_W-1:0]   prod_src, prod_fix;
    logic [DATA_W-1:0]     quo_fix, rem_fix, dz_hi;

    // MULT and DIV are the even opcodes; their operands enter as magnitudes.
    assign signed_op = ~in_op[0];
    assign sign_a    = signed_op & in_dataA[DATA_W-1];
    assign sign_b    = signed_op & in_dataB[DATA_W-1];

    // Restoring step: dividend bits stream out of a_q into the remainder half of acc.
    assign rem_sh  = {acc_q[2*DATA_W-1:DATA_W], a_q[DATA_W-1]};
    assign div_ge  = rem_sh >= {1'b0, b_q};
    assign div_sub = rem_sh[DATA_W-1:0] - b_q;

`ifdef MULDIV_FAST_MUL_EN
    assign prod_src = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
`else
    logic [DATA_W:0] mul_sum;

    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (b_q[0] ? a_q : '0)};
    assign prod_src = acc_q;
`endif

    assign prod_fix = neg_lo_q ? -prod_src : prod_src;
    assign quo_fix  = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign rem_fix  = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
    // a_q is untouched on divide by zero, so re-applying the sign restores the raw dividend.
    assign dz_hi    = neg_hi_q ? -a_q : a_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        dz_d       = dz_q;
        done_d     = 1'b0;
        dz_pulse_d = 1'b0;

        if (state_q != StIdle && in_flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_start && !in_flush) begin
                        case (in_op)
                            OpMthi: hi_d = in_dataA;
                            OpMtlo: lo_d = in_dataA;
                            OpMult, OpMultu, OpDiv, OpDivu: begin
                                a_d      = sign_a ? -in_dataA : in_dataA;
                                b_d      = sign_b ? -in_dataB : in_dataB;
                                neg_lo_d = sign_a ^ sign_b;
                                neg_hi_d = sign_a;
                                is_div_d = in_op[1];
                                dz_d     = in_op[1] && (in_dataB == '0);
                                acc_d    = '0;
                                cnt_d    = '0;
                                state_d  = in_op[1] ? StDiv : StMul;
                            end
                            default: ;
                        endcase
                    end
                end
                StMul: begin
`ifdef MULDIV_FAST_MUL_EN
                    hi_d    = prod_fix[2*DATA_W-1:DATA_W];
                    lo_d    = prod_fix[DATA_W-1:0];
                    done_d  = 1'b1;
                    state_d = StIdle;
`else
                    acc_d = {mul_sum, acc_q[DATA_W-1:1]};
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state_d = StFix;
                    end
`endif
                end
                StDiv: begin
                    if (dz_q) begin
                        state_d = StFix;
                    end else begin
                        a_d   = a_q << 1;
                        acc_d = {(div_ge ? div_sub : rem_sh[DATA_W-1:0]),
                                 acc_q[DATA_W-2:0], div_ge};
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_STEP) begin
                            state_d = StFix;
                        end
                    end
                end
                StFix: begin
                    if (is_div_q) begin
                        lo_d = dz_q ? DIV0_LO : quo_fix;
                        hi_d = dz_q ? dz_hi : rem_fix;
                    end else begin
                        hi_d = prod_fix[2*DATA_W-1:DATA_W];
                        lo_d = prod_fix[DATA_W-1:0];
                    end
                    done_d     = 1'b1;
                    dz_pulse_d = dz_q;
                    state_d    = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_q       <= 1'b0;
            done_q     <= 1'b0;
            dz_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            dz_q       <= dz_d;
            done_q     <= done_d;
            dz_pulse_q <= dz_pulse_d;
        end
    end

    assign out_busy        = (state_q != StIdle);
    assign out_done        = done_q;
    assign out_div_by_zero = dz_pulse_q;
    assign out_hi          = hi_q;
    assign out_lo          = lo_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: directed corner cases plus random ops against a
// plain-arithmetic HI/LO reference model.
module tb_ex_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_start = 1'b0;
    logic [2:0]  in_op = 3'b0;
    logic [31:0] in_dataA = '0;
    logic [31:0] in_dataB = '0;
    logic        in_flush = 1'b0;
    logic        out_busy, out_done, out_div_by_zero;
    logic [31:0] out_hi, out_lo;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MulLat = 1;
`else
    localparam int MulLat = 33;
`endif

    ex_muldiv_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_start        (in_start),
        .in_op           (in_op),
        .in_dataA        (in_dataA),
        .in_dataB        (in_dataB),
        .in_flush        (in_flush),
        .out_busy        (out_busy),
        .out_done        (out_done),
        .out_div_by_zero (out_div_by_zero),
        .out_hi          (out_hi),
        .out_lo          (out_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural result of one op given the current HI/LO.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        longint      sa, sb;
        logic [63:0] q, r;
        eh = m_hi;
        el = m_lo;
        case (op)
            3'd0: begin
                p  = longint'($signed(a)) * longint'($signed(b));
                eh = p[63:32];
                el = p[31:0];
            end
            3'd1: begin
                p  = {32'b0, a} * {32'b0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    eh = a;
                    el = 32'hFFFF_FFFF;
                end else if (op == 3'd2) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
            3'd4: eh = a;
            3'd5: el = a;
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge where done is expected (or idle for MT/undef).
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        logic [31:0] eh, el;
        int          n, lat;
        bit          md, dz;
        model(op, a, b, eh, el);
        md  = (op <= 3'd3);
        dz  = op[1] && !op[2] && (b == 0);
        lat = op[1] ? (dz ? 2 : 33) : MulLat;
        in_start = 1'b1;
        in_op    = op;
        in_dataA = a;
        in_dataB = b;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            in_op    = 3'd1;
            in_dataA = 32'd3;
            in_dataB = 32'd3;
        end else begin
            in_start = 1'b0;
        end
        n = 0;
        while (out_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        in_start = 1'b0;
        if (md) begin
            check({tag, "/busy_cycles"}, 64'(n), 64'(lat));
            check({tag, "/done"}, 64'(out_done), 64'd1);
            check({tag, "/dz"}, 64'(out_div_by_zero), 64'(dz));
        end else begin
            check({tag, "/busy_cycles"}, 64'(n), 64'd0);
            check({tag, "/done"}, 64'(out_done), 64'd0);
        end
        check({tag, "/hi"}, 64'(out_hi), 64'(eh));
        check({tag, "/lo"}, 64'(out_lo), 64'(el));
        m_hi = eh;
        m_lo = el;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int          seen;
        logic [2:0]  op;
        logic [31:0] ra, rb;

        #2 rst_n = 1'b0;
        #1;
        check("reset/busy", 64'(out_busy), 64'd0);
        check("reset/done", 64'(out_done), 64'd0);
        check("reset/dz", 64'(out_div_by_zero), 64'd0);
        check("reset/hi", 64'(out_hi), 64'd0);
        check("reset/lo", 64'(out_lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mult_m3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_op("multu_ffff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_ffff", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("div_m7d2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu_m7d2", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu_by0", 3'd3, 32'h0000_1234, 32'd0, 1'b0);
        run_op("div_by0_neg", 3'd2, 32'h8765_4321, 32'd0, 1'b0);
        run_op("mult_minsq", 3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("mtlo", 3'd5, 32'h1357_9BDF, 32'd0, 1'b0);
        run_op("undef_op", 3'd7, 32'hDEAD_BEEF, 32'd9, 1'b0);

        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 5));
            ra = rnd_val();
            rb = rnd_val();
            run_op($sformatf("rand%0d_op%0d", i, op), op, ra, rb, 1'b0);
        end

        // Flush mid-operation, then flush colliding with a start in idle.
        run_op("mthi", 3'd4, 32'hAAAA_5555, 32'd0, 1'b0);
        in_start = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
        in_op = 3'd3; in_dataA = 32'd42; in_dataB = 32'd1;
`else
        in_op = 3'd0; in_dataA = 32'd7;  in_dataB = 32'd6;
`endif
        @(posedge clk);
        @(negedge clk);
        in_start = 1'b0;
        repeat (9) @(negedge clk);
        in_flush = 1'b1;
        @(negedge clk);
        in_flush = 1'b0;
        check("flush/busy", 64'(out_busy), 64'd0);
        check("flush/done", 64'(out_done), 64'd0);
        check("flush/hi", 64'(out_hi), 64'(m_hi));
        check("flush/lo", 64'(out_lo), 64'(m_lo));
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_done) seen++;
        end
        check("flush/no_late_done", 64'(seen), 64'd0);

        in_flush = 1'b1;
        in_start = 1'b1;
        in_op    = 3'd4;
        in_dataA = 32'h1234_5678;
        @(negedge clk);
        in_op    = 3'd0;
        @(negedge clk);
        in_flush = 1'b0;
        in_start = 1'b0;
        check("flush_start/busy", 64'(out_busy), 64'd0);
        check("flush_start/hi", 64'(out_hi), 64'(m_hi));
        run_op("retry_mul", 3'd0, 32'd7, 32'd6, 1'b0);

        // Async reset mid-divide discards the op.
        in_start = 1'b1;
        in_op    = 3'd3;
        in_dataA = 32'd100;
        in_dataB = 32'd7;
        @(posedge clk);
        @(negedge clk);
        in_start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset/busy", 64'(out_busy), 64'd0);
        check("midreset/done", 64'(out_done), 64'd0);
        check("midreset/dz", 64'(out_div_by_zero), 64'd0);
        check("midreset/hi", 64'(out_hi), 64'd0);
        check("midreset/lo", 64'(out_lo), 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("divu_hold_start", 3'd3, 32'd100, 32'd7, 1'b1);
        @(negedge clk);
        check("after_hold/busy", 64'(out_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
